// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words from a valid/ready
// stream and writes them into instruction memory, holding the CPU in reset until done.
module imem_loader #(
    parameter int ADDR_W = 11,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [LEN_W-1:0]  words_written,
    output logic              cpu_hold
);

    // state | meaning
    // IDLE  | out of reset, waiting for start
    // HDR0  | waiting for word-count high byte
    // HDR1  | waiting for word-count low byte
    // DATA  | collecting the 4 bytes of the next word
    // WRITE | one-cycle memory write pulse
    // DONE  | image complete, CPU released
    // ERR   | image rejected (too long), CPU held

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    logic [7:0]        len_hi;
    logic [LEN_W-1:0]  len;
    logic [23:0]       asm_q;
    logic [1:0]        byte_idx;

    logic              accept;
    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_too_long;
    logic [LEN_W-1:0]  ww_next;
    logic              can_start;

    assign accept       = in_valid && in_ready;
    assign hdr_len      = LEN_W'({len_hi, in_data});
    assign hdr_too_long = 32'(hdr_len) > DEPTH;
    assign ww_next      = words_written + LEN_W'(1);
    assign can_start    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            len_hi        <= '0;
            len           <= '0;
            asm_q         <= '0;
            byte_idx      <= '0;
            in_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            cpu_hold      <= 1'b1;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (can_start && start) begin
                        state         <= S_HDR0;
                        in_ready      <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        words_written <= '0;
                        mem_addr      <= '0;
                        byte_idx      <= '0;
                        cpu_hold      <= 1'b1;
                    end
                end
                S_HDR0: begin
                    if (accept) begin
                        len_hi <= in_data;
                        state  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        len <= hdr_len;
                        if (hdr_len == '0) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else if (hdr_too_long) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_q    <= {asm_q[15:0], in_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_wdata <= {asm_q, in_data};
                            mem_we    <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // Address/count advance after the pulse so they stay stable during it.
                    mem_addr      <= mem_addr + 1'b1;
                    words_written <= ww_next;
                    if (ww_next == len) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state    <= S_DATA;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: streams hand-built images and checks the
// captured memory writes and status outputs against hand-computed values.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;
    logic        cpu_hold;

    int vectors = 0;
    int miscompares = 0;
    int we_with_ready = 0;

    logic [10:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.ADDR_W(11), .LEN_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .error(error),
        .words_written(words_written), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (in_ready) we_with_ready++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i]) send_byte(bytes[i], gaps);
    endtask

    task automatic wait_end();
        int t = 0;
        while (!done && !error && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("end_timeout", 32'(t), 32'd0);
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_ww"}, 32'(words_written), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_values("rst");
        reset_n = 1'b1;

        // 1: two-word image
        @(negedge clk);
        in_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(in_ready), 32'd1);
        send_bytes('{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                     8'h00, 8'h00, 8'h00, 8'h0C}, 1'b0);
        wait_end();
        chk("t1_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t1_a0", 32'(wr_addr[0]), 32'd0);
            chk("t1_d0", wr_data[0], 32'h24080005);
            chk("t1_a1", 32'(wr_addr[1]), 32'd1);
            chk("t1_d1", wr_data[1], 32'h0000000C);
        end
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_ww", 32'(words_written), 32'd2);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_addr_end", 32'(mem_addr), 32'd2);

        // 2: empty image
        clear_writes();
        pulse_start();
        chk("t2_hold_reassert", 32'(cpu_hold), 32'd1);
        chk("t2_done_clr", 32'(done), 32'd0);
        send_bytes('{8'h00, 8'h00}, 1'b0);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_ww", 32'(words_written), 32'd0);
        chk("t2_nwr", 32'(wr_addr.size()), 32'd0);
        chk("t2_hold", 32'(cpu_hold), 32'd0);

        // 3: oversize image rejected
        pulse_start();
        send_bytes('{8'h08, 8'h01}, 1'b0);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_hold", 32'(cpu_hold), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(negedge clk);
        chk("t3_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        chk("t3_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_start();
        chk("t3_error_clr", 32'(error), 32'd0);
        chk("t3_busy", 32'(busy), 32'd1);

        // 4: three words with random valid gaps (load already started above)
        send_bytes('{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
                     8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'hDE, 8'hAD, 8'h00, 8'h01}, 1'b1);
        wait_end();
        chk("t4_nwr", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("t4_a0", 32'(wr_addr[0]), 32'd0);
            chk("t4_d0", wr_data[0], 32'h11223344);
            chk("t4_a1", 32'(wr_addr[1]), 32'd1);
            chk("t4_d1", wr_data[1], 32'hA55A0FF0);
            chk("t4_a2", 32'(wr_addr[2]), 32'd2);
            chk("t4_d2", wr_data[2], 32'hDEAD0001);
        end
        chk("t4_ww", 32'(words_written), 32'd3);
        chk("t4_we_ready", 32'(we_with_ready), 32'd0);

        // 5: reset mid-load, then restart from address 0
        clear_writes();
        pulse_start();
        send_bytes('{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b0);
        chk("t5_ww_mid", 32'(words_written), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("t5_rst");
        @(negedge clk);
        reset_n = 1'b1;
        clear_writes();
        pulse_start();
        send_bytes('{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b0);
        wait_end();
        chk("t5_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t5_a0", 32'(wr_addr[0]), 32'd0);
            chk("t5_d0", wr_data[0], 32'hCAFEF00D);
        end

        // 6: start during DATA ignored, then back-to-back load from DONE
        clear_writes();
        pulse_start();
        send_bytes('{8'h00, 8'h02, 8'h10, 8'h20}, 1'b0);
        pulse_start();
        send_bytes('{8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80}, 1'b0);
        wait_end();
        chk("t6_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("t6_d0", wr_data[0], 32'h10203040);
            chk("t6_a1", 32'(wr_addr[1]), 32'd1);
            chk("t6_d1", wr_data[1], 32'h50607080);
        end
        chk("t6_ww", 32'(words_written), 32'd2);
        clear_writes();
        pulse_start();
        chk("t6_hold_reassert", 32'(cpu_hold), 32'd1);
        send_bytes('{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b0);
        wait_end();
        chk("t6b_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t6b_a0", 32'(wr_addr[0]), 32'd0);
            chk("t6b_d0", wr_data[0], 32'hDEADBEEF);
        end
        chk("t6b_done", 32'(done), 32'd1);
        chk("t6b_hold", 32'(cpu_hold), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
